pio_avalon_master: RTL and testbench

Avalon-MM initiator that drives the 8-bit PIO slaves in the subsystem (LED GPIO and similar), converting single-beat commands from a local controller into PIO register accesses. It issues data writes and set/clear-bit writes, and reads back the input port. It honours `waitrequest` and a fixed read latency, and returns one response per command. Its bus-side ports connect directly to a PIO slave's `address/chipselect/write_n/writedata/readdata`.

---
 rtl/pio_avalon_master.sv | 189 ++++++++++++++++++
 tb/tb_pio_avalon_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_avalon_master.sv
// Avalon-MM initiator for 8-bit-style PIO slaves: turns single-beat WRITE/SET/CLEAR/READ
// commands into one bus access each, with waitrequest handling, fixed read latency and a stall timeout.
module pio_avalon_master #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [2:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    localparam int unsigned AVM_W   = 32;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned LAT_W   = 3;
    localparam int unsigned STALL_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_DATA  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_SET   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ADDR_CLEAR = ADDR_W'(5);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_REQ,
        S_RD_WAIT,
        S_RSP
    } state_t;

    state_t              r_state,       w_state_nxt;
    logic [LAT_W-1:0]    r_lat_cnt,     w_lat_cnt_nxt;
    logic [STALL_W-1:0]  r_stall_cnt,   w_stall_cnt_nxt;
    logic                r_cs,          w_cs_nxt;
    logic                r_write_n,     w_write_n_nxt;
    logic [ADDR_W-1:0]   r_address,     w_address_nxt;
    logic [AVM_W-1:0]    r_writedata,   w_writedata_nxt;
    logic                r_rsp_valid,   w_rsp_valid_nxt;
    logic [DATA_W-1:0]   r_rsp_data,    w_rsp_data_nxt;
    logic                r_rsp_err,     w_rsp_err_nxt;
    logic                r_cmd_ready,   w_cmd_ready_nxt;
    logic                r_busy,        w_busy_nxt;

    // Upper readdata bits are not part of the PIO data path.
    generate
        if (DATA_W < AVM_W) begin : g_rd_unused
            logic w_unused_rd;
            assign w_unused_rd = ^avm_readdata[AVM_W-1:DATA_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_lat_cnt   <= '0;
            r_stall_cnt <= '0;
            r_cs        <= 1'b0;
            r_write_n   <= 1'b1;
            r_address   <= '0;
            r_writedata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lat_cnt   <= w_lat_cnt_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
            r_cs        <= w_cs_nxt;
            r_write_n   <= w_write_n_nxt;
            r_address   <= w_address_nxt;
            r_writedata <= w_writedata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state and next-output logic; every bus output is computed one cycle ahead.
    always_comb begin
        w_state_nxt     = r_state;
        w_lat_cnt_nxt   = r_lat_cnt;
        w_stall_cnt_nxt = r_stall_cnt;
        w_cs_nxt        = r_cs;
        w_write_n_nxt   = r_write_n;
        w_address_nxt   = r_address;
        w_writedata_nxt = r_writedata;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_data_nxt  = '0;
        w_rsp_err_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_cs_nxt        = 1'b1;
                    w_stall_cnt_nxt = '0;
                    w_writedata_nxt = AVM_W'(cmd_data);
                    w_write_n_nxt   = 1'b0;
                    w_state_nxt     = S_WR;
                    case (cmd_op)
                        2'b00:   w_address_nxt = ADDR_DATA;
                        2'b01:   w_address_nxt = ADDR_SET;
                        2'b10:   w_address_nxt = ADDR_CLEAR;
                        default: begin
                            w_address_nxt   = ADDR_DATA;
                            w_write_n_nxt   = 1'b1;
                            w_writedata_nxt = '0;
                            w_state_nxt     = S_RD_REQ;
                        end
                    endcase
                end
            end

            S_WR, S_RD_REQ: begin
                if (!avm_waitrequest) begin
                    w_cs_nxt        = 1'b0;
                    w_write_n_nxt   = 1'b1;
                    w_address_nxt   = '0;
                    w_writedata_nxt = '0;
                    if (r_state == S_WR) begin
                        w_rsp_valid_nxt = 1'b1;
                        w_state_nxt     = S_RSP;
                    end else begin
                        w_lat_cnt_nxt = LAT_W'(READ_LATENCY);
                        w_state_nxt   = S_RD_WAIT;
                    end
                end else if (r_stall_cnt == STALL_W'(TIMEOUT)) begin
                    // Slave has stalled too long: abandon the cycle and report an error.
                    w_cs_nxt        = 1'b0;
                    w_write_n_nxt   = 1'b1;
                    w_address_nxt   = '0;
                    w_writedata_nxt = '0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_state_nxt     = S_RSP;
                end else begin
                    w_stall_cnt_nxt = r_stall_cnt + STALL_W'(1);
                end
            end

            S_RD_WAIT: begin
                if (r_lat_cnt == LAT_W'(1)) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = avm_readdata[DATA_W-1:0];
                    w_state_nxt     = S_RSP;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt - LAT_W'(1);
                end
            end

            S_RSP: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
    end

    assign cmd_ready      = r_cmd_ready;
    assign busy           = r_busy;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign rsp_err        = r_rsp_err;
    assign avm_chipselect = r_cs;
    assign avm_write_n    = r_write_n;
    assign avm_address    = r_address;
    assign avm_writedata  = r_writedata;

endmodule

// File: tb/tb_pio_avalon_master.sv
// Bench for pio_avalon_master: a PIO slave model with programmable stalls and read latency,
// plus an abstract expected-port model and cycle-latency expectations per command.
module tb_pio_avalon_master;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned RL     = 3;
    localparam int unsigned TO     = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;
    logic [2:0]        avm_address;
    logic              avm_chipselect;
    logic              avm_write_n;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata = '0;
    logic              avm_waitrequest = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] out_port = '0;
    logic [DATA_W-1:0] in_port  = '0;
    logic [DATA_W-1:0] exp_out  = '0;
    int                cfg_stall = 0;
    bit                cfg_stuck = 1'b0;
    int                cs_run = 0;
    int                rd_cd  = 0;

    pio_avalon_master #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (RL),
        .TIMEOUT      (TO)
    ) u_dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_data        (cmd_data),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rsp_err         (rsp_err),
        .busy            (busy),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write_n     (avm_write_n),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // PIO slave model: registers change only on accepted (non-stalled) cycles.
    always @(negedge clk) begin
        logic [31:0] rd_word;
        if (!reset_n) begin
            cs_run          = 0;
            rd_cd           = 0;
            avm_waitrequest = 1'b0;
        end else begin
            if (avm_chipselect) begin
                avm_waitrequest = cfg_stuck || (cs_run < cfg_stall);
                cs_run++;
            end else begin
                cs_run          = 0;
                avm_waitrequest = 1'($urandom_range(1, 0));
            end
            rd_word = $urandom();
            if (rd_cd > 0) begin
                rd_cd--;
                if (rd_cd == 0) rd_word[DATA_W-1:0] = in_port;
            end
            avm_readdata = rd_word;
            if (avm_chipselect && !avm_waitrequest) begin
                if (avm_write_n) begin
                    rd_cd = RL;
                end else begin
                    case (avm_address)
                        3'd0:    out_port = avm_writedata[DATA_W-1:0];
                        3'd4:    out_port = out_port | avm_writedata[DATA_W-1:0];
                        3'd5:    out_port = out_port & ~avm_writedata[DATA_W-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rsp"}, {22'd0, rsp_valid, rsp_err, rsp_data}, 32'd0);
        chk({tag, "_cs"}, 32'(avm_chipselect), 32'd0);
        chk({tag, "_write_n"}, 32'(avm_write_n), 32'd1);
        chk({tag, "_addr"}, 32'(avm_address), 32'd0);
        chk({tag, "_wdata"}, avm_writedata, 32'd0);
    endtask

    // Issue one command at the current negedge and check the whole transaction.
    task automatic do_cmd(input logic [1:0] op, input logic [DATA_W-1:0] d,
                          input logic [DATA_W-1:0] rd_val, input int stall, input bit stuck);
        int          w;
        int          got_k;
        int          exp_k;
        int          cs_cycles;
        bit          bus_bad;
        bit          hs_bad;
        logic [DATA_W-1:0] rdat;
        logic        err;
        logic [2:0]  exp_addr;
        logic        exp_wn;
        logic [DATA_W-1:0] exp_data;

        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);

        cfg_stall = stall;
        cfg_stuck = stuck;
        in_port   = rd_val;
        exp_addr  = (op == 2'b01) ? 3'd4 : (op == 2'b10) ? 3'd5 : 3'd0;
        exp_wn    = (op == 2'b11);
        exp_k     = stuck ? int'(TO) + 2 : stall + 2 + ((op == 2'b11) ? int'(RL) : 0);

        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom());
        cmd_data  = DATA_W'($urandom());

        got_k = 0; cs_cycles = 0; bus_bad = 0; hs_bad = 0; rdat = '0; err = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            if (k > 1) @(negedge clk);
            if (avm_chipselect) begin
                cs_cycles++;
                if (avm_address != exp_addr || avm_write_n != exp_wn ||
                    (!exp_wn && avm_writedata != 32'(d)))
                    bus_bad = 1'b1;
            end
            if (!busy || cmd_ready) hs_bad = 1'b1;
            if (rsp_valid) begin
                got_k = k;
                rdat  = rsp_data;
                err   = rsp_err;
                break;
            end
        end

        exp_data = (op == 2'b11 && !stuck) ? rd_val : '0;
        if (!stuck) begin
            case (op)
                2'b00:   exp_out = d;
                2'b01:   exp_out = exp_out | d;
                2'b10:   exp_out = exp_out & ~d;
                default: ;
            endcase
        end

        chk("rsp_latency", 32'(got_k), 32'(exp_k));
        chk("cs_cycles", 32'(cs_cycles), 32'(stuck ? int'(TO) + 1 : stall + 1));
        chk("bus_fields", 32'(bus_bad), 32'd0);
        chk("busy_ready", 32'(hs_bad), 32'd0);
        chk("rsp_err", 32'(err), 32'(stuck));
        chk("rsp_data", 32'(rdat), 32'(exp_data));
        chk("out_port", 32'(out_port), 32'(exp_out));

        @(negedge clk);
        chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        chk("ready_after_rsp", 32'(cmd_ready), 32'd1);
        chk("idle_bus", {28'd0, avm_chipselect, avm_address}, 32'd0);
        chk("idle_bus_wn_wd", {avm_writedata[30:0], avm_write_n}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_rsp_seen;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("after_reset");

        do_cmd(2'b00, 8'hA5, 8'h00, 0, 1'b0);
        do_cmd(2'b00, 8'hA0, 8'h00, 0, 1'b0);
        do_cmd(2'b01, 8'h0F, 8'h00, 0, 1'b0);
        do_cmd(2'b10, 8'h05, 8'h00, 0, 1'b0);
        do_cmd(2'b11, 8'h00, 8'h3C, 0, 1'b0);
        do_cmd(2'b00, 8'h5A, 8'h00, 4, 1'b0);
        do_cmd(2'b11, 8'h00, 8'hC3, 3, 1'b0);
        do_cmd(2'b01, 8'h81, 8'h00, 0, 1'b1);
        do_cmd(2'b11, 8'h00, 8'h77, 0, 1'b1);
        do_cmd(2'b00, 8'h3D, 8'h00, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = int'($urandom_range(2, 0));
            repeat (gap) @(negedge clk);
            do_cmd(2'($urandom()), DATA_W'($urandom()), DATA_W'($urandom()),
                   int'($urandom_range(5, 0)), ($urandom_range(9, 0) == 0));
        end

        // Reset while a read is in its latency wait.
        cfg_stall = 0;
        cfg_stuck = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("mid_read_reset");
        rd_rsp_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid) rd_rsp_seen++;
        end
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid) rd_rsp_seen++;
        end
        chk("no_rsp_after_reset", 32'(rd_rsp_seen), 32'd0);
        chk_reset_vals("post_reset_idle");

        do_cmd(2'b00, 8'h11, 8'h00, 0, 1'b0);
        do_cmd(2'b00, 8'h22, 8'h00, 0, 1'b0);
        do_cmd(2'b01, 8'h40, 8'h00, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
